uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver that is the downstream partner of uart_tx. It consumes the tx line (8N1 framing, LSB first, idle high) and recovers parallel bytes. Each byte is presented with a one-cycle data_valid strobe. It is used in loopback with uart_tx and as the receive path of the UART subsystem.

Parameters:
CLKS_PER_BIT, 16, clock cycles per bit period; must equal the uart_tx bit period; minimum 4, even.
DATA_BITS, 8, data bits per frame.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
rx  input  1  serial input, idle high, asynchronous to clk.
data_out  output  DATA_BITS  last correctly received byte.
data_valid  output  1  one-cycle strobe; data_out is new.
busy  output  1  high while a frame is being received.
frame_err  output  1  one-cycle strobe; stop bit sampled low.
parity_err  output  1  one-cycle strobe; parity mismatch (tied 0 without UART_RX_PARITY_EN).

Behaviour:
- Reset and clocking:
  - One clock (clk). Reset is synchronous and active-high (rst).
  - rst forces state IDLE, bit/clock counters to 0, shift register to 0, synchronizer flops to 1.
  - rst forces data_out=0, data_valid=0, busy=0, frame_err=0, parity_err=0.
- Input synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s, which adds 2 cycles of latency.
- State machine: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE. A single clk_cnt counts 0..CLKS_PER_BIT-1.
- IDLE: busy=0. rx_s low goes to START with clk_cnt=0.
- START:
  - At clk_cnt=CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - If rx_s=0, go to DATA with clk_cnt=0 and bit_idx=0.
  - If rx_s=1, treat it as a glitch and return to IDLE with no strobe.
- DATA:
  - At clk_cnt=CLKS_PER_BIT-1, sample rx_s into shift register bit bit_idx (LSB first), reset clk_cnt, increment bit_idx.
  - After bit DATA_BITS-1, go to PARITY if the macro is defined, otherwise to STOP.
- STOP: at clk_cnt=CLKS_PER_BIT-1, sample rx_s.
  - If 1 and no parity error: data_out<=shift register, data_valid=1 for one cycle, go to IDLE.
  - If 0: frame_err=1 for one cycle, data_out unchanged, no data_valid, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1 (break or line held low), then go to IDLE. busy stays high.
- busy=1 in every state except IDLE.
- Timing:
  - data_valid asserts mid stop bit, (DATA_BITS+1.5)*CLKS_PER_BIT+2 cycles after the rx falling edge, ±1 cycle.
  - Back-to-back frames are accepted: the next start edge is seen from IDLE half a bit after the strobe.
- Outputs are registered. Strobes are never asserted together: frame_err takes priority over parity_err, and both suppress data_valid.
- Reset asserted mid-frame aborts the frame with no strobe. The receiver restarts only on a fresh falling edge after rst is released, so a line already low resynchronizes when it next goes high then low.

Optional Feature:
UART_RX_PARITY_EN: when defined, the receiver inserts a PARITY state after DATA.
- It samples one even-parity bit at mid bit.
- A mismatch with the XOR of the data bits gives parity_err=1 for one cycle in the STOP-decision cycle, no data_valid, and data_out unchanged.
- When undefined, the PARITY state is not generated, the frame is 8N1, and parity_err is constant 0.
- The matching uart_tx must be built with the same macro.

Decomposition:
- uart_pkg holds:
  - the rx state enum;
  - default CLKS_PER_BIT and DATA_BITS constants, shared with uart_tx;
  - a parity function (XOR reduce).
- Sub-module uart_rx_sync: 2-flop synchronizer with reset value 1. It is also reusable for other async inputs.

Test Plan:
- Loopback with uart_tx (CLKS_PER_BIT=16): send 8'hA5 → one data_valid pulse with data_out=8'hA5; frame_err=0; busy rises ~3 cycles after the tx start edge and falls after the strobe.
- Back-to-back frames 8'h00 then 8'hFF with no idle gap → two data_valid pulses, data_out 8'h00 then 8'hFF, no errors.
- Glitch: rx low for 4 clocks, then high → returns to IDLE, no strobes, busy=0 within CLKS_PER_BIT/2+3 cycles.
- Framing: drive 8'h3C with stop bit low for 3 bit times → frame_err pulse, no data_valid, data_out keeps its previous value, busy held until rx high, then IDLE.
- Reset mid-frame: assert rst during data bit 4 for 1 cycle → all outputs 0 next cycle; a following 8'h5A frame is received correctly.
- Parity (macro defined): send 8'h07 with the correct parity bit 1 → data_valid with 8'h07. Send it with parity bit flipped → parity_err pulse and no data_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default framing constants, parity helper.
// UART_RX_PARITY_EN adds the PARITY state to the receiver encoding.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    // Even parity over up to 16 data bits; narrower words are zero-extended by the caller.
    function automatic logic uart_parity(input logic [15:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; q_o lags d_i by 2 clocks.
// Reset loads RST_VAL so an idle-high line never shows a spurious edge.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (LSB first, idle high), data sampled mid-bit, one-cycle result strobes.
// Optional even parity bit after the data when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err
);
    localparam int CNTW = $clog2(CLKS_PER_BIT);
    localparam int IDXW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNTW-1:0] HALF_M1  = CNTW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNTW-1:0] FULL_M1  = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    logic [1:0]           settle_q;
    logic                 start_edge;
    rx_state_e            state_q;
    logic [CNTW-1:0]      clk_cnt_q;
    logic [IDXW-1:0]      bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q;
    logic                 par_bad_q;
`endif

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // The synchronizer holds its reset value for two clocks; rx_prev_q ignores that window so a
    // line already low at reset release needs a real high-then-low before a frame starts.
    assign start_edge = rx_prev_q & ~rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q  <= '0;
            rx_prev_q <= 1'b0;
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            settle_q  <= {settle_q[0], 1'b1};
            rx_prev_q <= rx_s & settle_q[1];
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_q   <= ST_START;
                        clk_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (clk_cnt_q == HALF_M1) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        if (!rx_s) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        bit_idx_q          <= bit_idx_q + 1'b1;
                        if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q <= '0;
                        par_bad_q <= rx_s ^ uart_parity(16'(shift_q));
                        state_q   <= ST_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q <= '0;
                        if (!rx_s) begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad_q) begin
                            perr_q  <= 1'b1;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
`endif
                        end else begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames driven bit by bit, expected strobes queued and checked
// by an independent monitor. Parity cases are built only with UART_RX_PARITY_EN.
module tb_uart_rx;
    localparam int CPB = 16;

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_PERR  = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int         tests;
    int         fails;
    exp_t       exp_q[$];
    logic [7:0] last_data;
    logic [2:0] got;
    exp_t       e;
    int         cnt;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic [2:0] kind, input logic [7:0] data);
        exp_t x;
        x.kind = kind;
        x.data = data;
        exp_q.push_back(x);
    endtask

    task automatic bit_period(input logic val, input int n);
        rx = val;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, optional parity, then stop level held for stop_bits.
    task automatic send_frame(input logic [7:0] d, input int stop_bits, input logic stop_val,
                              input logic par_flip);
        bit_period(1'b0, 1);
        for (int i = 0; i < 8; i++) bit_period(d[i], 1);
`ifdef UART_RX_PARITY_EN
        bit_period((^d) ^ par_flip, 1);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        bit_period(stop_val, stop_bits);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && (data_valid || frame_err || parity_err)) begin
            got = {parity_err, frame_err, data_valid};
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {29'd0, got}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", {29'd0, got}, {29'd0, e.kind});
                if (e.kind == K_VALID) begin
                    chk("data_out", {24'd0, data_out}, {24'd0, e.data});
                    last_data = e.data;
                end else begin
                    chk("data_out_held", {24'd0, data_out}, {24'd0, last_data});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests     = 0;
        fails     = 0;
        last_data = 8'h00;
        rst       = 1'b1;
        rx        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Single frame with busy timing and strobe latency.
        expect_evt(K_VALID, 8'hA5);
        fork
            send_frame(8'hA5, 1, 1'b1, 1'b0);
            begin
                repeat (2) @(negedge clk);
                chk("busy_before_detect", {31'd0, busy}, 32'd0);
                repeat (2) @(negedge clk);
                chk("busy_after_detect", {31'd0, busy}, 32'd1);
                cnt = 4;
                while (!data_valid && cnt < 200) begin
                    @(negedge clk);
                    cnt++;
                end
                tests++;
                if (cnt < 153 || cnt > 156) begin
                    fails++;
                    $display("FAIL valid_latency: actual %0d cycles required 153..156", cnt);
                end
            end
        join
        chk("busy_after_frame", {31'd0, busy}, 32'd0);

        // Back-to-back frames with no idle gap.
        expect_evt(K_VALID, 8'h00);
        expect_evt(K_VALID, 8'hFF);
        send_frame(8'h00, 1, 1'b1, 1'b0);
        send_frame(8'hFF, 1, 1'b1, 1'b0);
        repeat (8) @(negedge clk);

        // Short glitch: no strobe, back to idle within half a bit plus 3.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (CPB / 2 + 3 - 4) @(negedge clk);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        repeat (CPB) @(negedge clk);

        // Stop bit low for 3 bit times: frame error, busy until the line returns high.
        expect_evt(K_FERR, 8'h3C);
        send_frame(8'h3C, 3, 1'b0, 1'b0);
        chk("wait_idle_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("wait_idle_exit", {31'd0, busy}, 32'd0);
        repeat (CPB) @(negedge clk);

        // One-cycle reset during data bit 4 of an aborted frame.
        fork
            send_frame(8'hF0, 1, 1'b1, 1'b0);
            begin
                repeat (CPB * 5 + 8) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                last_data = 8'h00;
                chk("midrst_data_out", {24'd0, data_out}, 32'd0);
                chk("midrst_valid", {31'd0, data_valid}, 32'd0);
                chk("midrst_busy", {31'd0, busy}, 32'd0);
                chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
                chk("midrst_perr", {31'd0, parity_err}, 32'd0);
                rst = 1'b0;
            end
        join
        repeat (8) @(negedge clk);
        expect_evt(K_VALID, 8'h5A);
        send_frame(8'h5A, 1, 1'b1, 1'b0);
        repeat (8) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        expect_evt(K_VALID, 8'h07);
        send_frame(8'h07, 1, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        expect_evt(K_PERR, 8'h07);
        send_frame(8'h07, 1, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
`endif

        repeat (2 * CPB) @(negedge clk);
        chk("pending_expectations", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
